// File: rtl/cacc_mac_rcv.sv
// cacc_mac_rcv: receive buffer between the MAC array and the accumulator.
// Packets from the MAC (no backpressure) are captured in a small FIFO and
// presented downstream under valid/ready. Also tracks popped stripe ends,
// pulses layer_done at a layer's last stripe, and flags FIFO overflow.
//
// Ports:
//   nvdla_core_clk   sole clock, rising edge
//   nvdla_core_rst   synchronous active-high reset
//   cfg_reg_en       layer-start pulse; clears stripe_cnt and rcv_err
//   mac2accu_pvld    incoming packet valid
//   mac2accu_mask    per-lane valid of the incoming packet
//   mac2accu_pd      stripe info {layer_end, channel_end, stripe_end, stripe_st, batch[4:0]}
//   mac2accu_data    lane results, lane k at [k*RESULT_WIDTH +: RESULT_WIDTH]
//   acc_pvld/prdy    downstream handshake
//   acc_mask/pd/data head entry of the FIFO
//   stripe_cnt       saturating count of popped stripe_end packets
//   layer_done       one-cycle pulse after popping a layer's final stripe
//   rcv_err          sticky overflow flag
module cacc_mac_rcv #(
  parameter int unsigned ATOMK_HALF   = 8,
  parameter int unsigned RESULT_WIDTH = 19,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                                 nvdla_core_clk,
  input  logic                                 nvdla_core_rst,
  input  logic                                 cfg_reg_en,
  input  logic                                 mac2accu_pvld,
  input  logic [ATOMK_HALF-1:0]                mac2accu_mask,
  input  logic [8:0]                           mac2accu_pd,
  input  logic [ATOMK_HALF*RESULT_WIDTH-1:0]   mac2accu_data,
  output logic                                 acc_pvld,
  input  logic                                 acc_prdy,
  output logic [ATOMK_HALF-1:0]                acc_mask,
  output logic [8:0]                           acc_pd,
  output logic [ATOMK_HALF*RESULT_WIDTH-1:0]   acc_data,
  output logic [15:0]                          stripe_cnt,
  output logic                                 layer_done,
  output logic                                 rcv_err
);

  localparam int unsigned DW = ATOMK_HALF * RESULT_WIDTH;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [ATOMK_HALF-1:0] mask_mem [DEPTH];
  logic [8:0]            pd_mem   [DEPTH];
  logic [DW-1:0]         data_mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   stripe_cnt_q, stripe_cnt_d;
  logic          layer_done_q, layer_done_d;
  logic          rcv_err_q, rcv_err_d;

  logic          push, pop, full, wr_en, overflow;
  logic [8:0]    head_pd;
  logic [DW-1:0] wr_data;

  // Zero masked-off lanes before storage so the head never exposes stale lanes.
  always_comb begin
    wr_data = '0;
    for (int unsigned k = 0; k < ATOMK_HALF; k++) begin
      if (mac2accu_mask[k]) begin
        wr_data[k*RESULT_WIDTH +: RESULT_WIDTH] = mac2accu_data[k*RESULT_WIDTH +: RESULT_WIDTH];
      end
    end
  end

  // Handshake decode; a pop in the same cycle frees a slot for a push at full.
  always_comb begin
    push     = mac2accu_pvld & ~nvdla_core_rst;
    full     = (cnt_q == CW'(DEPTH));
    pop      = acc_pvld & acc_prdy;
    wr_en    = push & (~full | pop);
    overflow = push & full & ~pop;
    head_pd  = pd_mem[rd_ptr_q];
  end

  // Next-state for pointers, occupancy and status.
  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    stripe_cnt_d = stripe_cnt_q;
    layer_done_d = 1'b0;
    rcv_err_d    = rcv_err_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(wr_en) - CW'(pop);

    if (pop && head_pd[6]) begin
      if (stripe_cnt_q != 16'hFFFF) stripe_cnt_d = stripe_cnt_q + 16'd1;
      layer_done_d = head_pd[8];
    end
    if (overflow) rcv_err_d = 1'b1;

    // Layer start wins over a same-cycle increment or error set.
    if (cfg_reg_en) begin
      stripe_cnt_d = '0;
      rcv_err_d    = 1'b0;
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      cnt_q        <= '0;
      stripe_cnt_q <= '0;
      layer_done_q <= 1'b0;
      rcv_err_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      stripe_cnt_q <= stripe_cnt_d;
      layer_done_q <= layer_done_d;
      rcv_err_q    <= rcv_err_d;
    end
  end

  // Storage is not reset; mask/pd outputs are qualified by occupancy instead.
  always_ff @(posedge nvdla_core_clk) begin
    if (wr_en) begin
      mask_mem[wr_ptr_q] <= mac2accu_mask;
      pd_mem[wr_ptr_q]   <= mac2accu_pd;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    acc_pvld   = (cnt_q != '0);
    acc_mask   = acc_pvld ? mask_mem[rd_ptr_q] : '0;
    acc_pd     = acc_pvld ? pd_mem[rd_ptr_q]   : '0;
    acc_data   = data_mem[rd_ptr_q];
    stripe_cnt = stripe_cnt_q;
    layer_done = layer_done_q;
    rcv_err    = rcv_err_q;
  end

endmodule

// File: tb/tb_cacc_mac_rcv.sv
// Bench for cacc_mac_rcv: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_cacc_mac_rcv;

  localparam int unsigned AH    = 8;
  localparam int unsigned RW    = 19;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = AH * RW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg = 1'b0;
  logic          pvld = 1'b0;
  logic          prdy = 1'b0;
  logic [AH-1:0] mask = '0;
  logic [8:0]    pd = '0;
  logic [DW-1:0] data = '0;

  logic          acc_pvld;
  logic [AH-1:0] acc_mask;
  logic [8:0]    acc_pd;
  logic [DW-1:0] acc_data;
  logic [15:0]   stripe_cnt;
  logic          layer_done;
  logic          rcv_err;

  cacc_mac_rcv #(.ATOMK_HALF(AH), .RESULT_WIDTH(RW), .DEPTH(DEPTH)) dut (
    .nvdla_core_clk (clk),
    .nvdla_core_rst (rst),
    .cfg_reg_en     (cfg),
    .mac2accu_pvld  (pvld),
    .mac2accu_mask  (mask),
    .mac2accu_pd    (pd),
    .mac2accu_data  (data),
    .acc_pvld       (acc_pvld),
    .acc_prdy       (prdy),
    .acc_mask       (acc_mask),
    .acc_pd         (acc_pd),
    .acc_data       (acc_data),
    .stripe_cnt     (stripe_cnt),
    .layer_done     (layer_done),
    .rcv_err        (rcv_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  function automatic void chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, a, e, $time);
    end
  endfunction

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [AH-1:0] m;
    logic [8:0]    p;
    logic [DW-1:0] d;
  } pkt_t;

  pkt_t q[$];
  int   m_stripe = 0;
  bit   m_ld = 1'b0;
  bit   m_err = 1'b0;

  function automatic pkt_t mk(logic [AH-1:0] m, logic [8:0] p, logic [DW-1:0] d);
    pkt_t r;
    r.m = m;
    r.p = p;
    r.d = '0;
    for (int k = 0; k < int'(AH); k++)
      if (m[k]) r.d[k*RW +: RW] = d[k*RW +: RW];
    return r;
  endfunction

  always @(posedge clk) begin : model
    pkt_t h;
    bit   po;
    bit   ov;
    h  = '0;
    ov = 1'b0;
    if (rst) begin
      q.delete();
      m_stripe = 0;
      m_ld     = 1'b0;
      m_err    = 1'b0;
    end else begin
      po   = (q.size() != 0) && prdy;
      m_ld = 1'b0;
      if (po) begin
        h    = q.pop_front();
        m_ld = h.p[6] && h.p[8];
      end
      if (cfg) m_stripe = 0;
      else if (po && h.p[6] && m_stripe < 65535) m_stripe++;
      if (pvld) begin
        if (q.size() < int'(DEPTH)) q.push_back(mk(mask, pd, data));
        else ov = 1'b1;
      end
      if (cfg) m_err = 1'b0;
      else if (ov) m_err = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin : compare
    chk("acc_pvld", 32'(acc_pvld), 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("acc_mask", 32'(acc_mask), 32'(q[0].m));
      chk("acc_pd", 32'(acc_pd), 32'(q[0].p));
      for (int k = 0; k < int'(AH); k++)
        chk("acc_data_lane", 32'(acc_data[k*RW +: RW]), 32'(q[0].d[k*RW +: RW]));
    end else begin
      chk("acc_mask_idle", 32'(acc_mask), 32'd0);
      chk("acc_pd_idle", 32'(acc_pd), 32'd0);
    end
    chk("stripe_cnt", 32'(stripe_cnt), 32'(m_stripe));
    chk("layer_done", 32'(layer_done), 32'(m_ld));
    chk("rcv_err", 32'(rcv_err), 32'(m_err));
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(bit v, logic [AH-1:0] m, logic [8:0] p, logic [DW-1:0] d, bit r);
    pvld = v;
    mask = m;
    pd   = p;
    data = d;
    prdy = r;
  endtask

  task automatic drain();
    drive(1'b0, '0, '0, '0, 1'b1);
    repeat (DEPTH + 1) cyc();
  endtask

  logic [DW-1:0] dv;
  logic [8:0]    exp_pd;

  initial begin
    rst = 1'b1;
    repeat (3) cyc();
    chk("reset_pvld", 32'(acc_pvld), 32'd0);
    chk("reset_stripe", 32'(stripe_cnt), 32'd0);
    chk("reset_err", 32'(rcv_err), 32'd0);
    rst = 1'b0;
    cyc();

    // single packet, downstream always ready
    dv = '1;
    dv[RW-1:0] = 19'h12345;
    drive(1'b1, 8'h0F, 9'h040, dv, 1'b1);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("t1_pvld", 32'(acc_pvld), 32'd1);
    chk("t1_lane0", 32'(acc_data[RW-1:0]), 32'h12345);
    chk("t1_lane1", 32'(acc_data[2*RW-1:RW]), 32'h7FFFF);
    chk("t1_hi_zero", 32'(|acc_data[DW-1:4*RW]), 32'd0);
    cyc();
    chk("t1_pvld_gone", 32'(acc_pvld), 32'd0);
    chk("t1_stripe", 32'(stripe_cnt), 32'd1);

    // fill then overflow
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'hFF, 9'(i + 1), DW'(i + 1), 1'b0);
      cyc();
    end
    chk("t2_err", 32'(rcv_err), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_pvld", 32'(acc_pvld), 32'd1);
      chk("t2_order", 32'(acc_pd), 32'(i + 1));
      cyc();
    end
    chk("t2_empty", 32'(acc_pvld), 32'd0);
    cfg = 1'b1;
    cyc();
    cfg = 1'b0;
    chk("t2_err_clr", 32'(rcv_err), 32'd0);
    chk("t2_stripe_clr", 32'(stripe_cnt), 32'd0);

    // full with concurrent push and pop
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8'hFF, 9'(9'h010 + i), DW'($urandom), 1'b0);
      cyc();
    end
    for (int j = 0; j < 10; j++) begin
      drive(1'b1, 8'hFF, 9'(9'h020 + j), DW'($urandom), 1'b1);
      cyc();
      exp_pd = (j + 1 < 4) ? 9'(9'h010 + j + 1) : 9'(9'h020 + j + 1 - 4);
      chk("t3_order", 32'(acc_pd), 32'(exp_pd));
      chk("t3_err", 32'(rcv_err), 32'd0);
    end
    drain();

    // layer end pulse only with stripe_end
    drive(1'b1, 8'hFF, 9'h140, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("t4_ld_pre", 32'(layer_done), 32'd0);
    cyc();
    chk("t4_ld_pulse", 32'(layer_done), 32'd1);
    cyc();
    chk("t4_ld_end", 32'(layer_done), 32'd0);
    drive(1'b1, 8'hFF, 9'h100, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    cyc();
    chk("t4_no_pulse", 32'(layer_done), 32'd0);

    // cfg_reg_en beats a same-cycle stripe increment
    drive(1'b1, 8'hFF, 9'h040, '0, 1'b1);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    cfg = 1'b1;
    cyc();
    cfg = 1'b0;
    chk("t5_stripe_zero", 32'(stripe_cnt), 32'd0);

    // cfg_reg_en clears rcv_err without flushing
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'h3C, 9'(9'h0A0 + i), DW'($urandom), 1'b0);
      cyc();
    end
    chk("t5_err_set", 32'(rcv_err), 32'd1);
    drive(1'b0, '0, '0, '0, 1'b0);
    cfg = 1'b1;
    cyc();
    cfg = 1'b0;
    chk("t5_err_clr", 32'(rcv_err), 32'd0);
    chk("t5_intact", 32'(acc_pd), 32'h0A0);
    drain();

    // reset mid-stream with a concurrent push
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 8'hFF, 9'(9'h030 + i), DW'($urandom), 1'b0);
      cyc();
    end
    drive(1'b1, 8'hFF, 9'h1FF, '1, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    drive(1'b0, '0, '0, '0, 1'b0);
    chk("t6_flushed", 32'(acc_pvld), 32'd0);
    drive(1'b1, 8'hFF, 9'h0AA, '0, 1'b0);
    cyc();
    drive(1'b0, '0, '0, '0, 1'b1);
    chk("t6_next", 32'(acc_pd), 32'h0AA);
    drain();

    // randomized traffic with varying downstream pressure
    for (int seg = 0; seg < 20; seg++) begin
      int rdy_pct;
      rdy_pct = int'($urandom_range(10, 100));
      for (int c = 0; c < 100; c++) begin
        rst  = ($urandom_range(0, 299) == 0);
        cfg  = ($urandom_range(0, 39) == 0);
        pvld = ($urandom_range(0, 3) != 0);
        prdy = (int'($urandom_range(1, 100)) <= rdy_pct);
        mask = AH'($urandom);
        pd   = 9'($urandom);
        for (int k = 0; k < int'(AH); k++) data[k*RW +: RW] = RW'($urandom);
        cyc();
      end
    end
    rst = 1'b0;
    cfg = 1'b0;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
